// File: rtl/hdbn_encoder_if.sv
// Beat-level bus between an NRZ source and the HDB-N line encoder.
//   i_valid : qualifies i_data/i_ami, one beat per cycle with i_valid=1
//   i_data  : NRZ data bit
//   i_ami   : 1 = plain AMI, 0 = HDB-N substitution
//   o_valid : one-cycle strobe for a new output symbol
//   o_code  : symbol type (00 zero, 01 one, 10 V, 11 B)
//   o_pos   : positive line pulse
//   o_neg   : negative line pulse
interface hdbn_encoder_if;
  logic       i_valid;
  logic       i_data;
  logic       i_ami;
  logic       o_valid;
  logic [1:0] o_code;
  logic       o_pos;
  logic       o_neg;

  // Source side: drives beats, observes line symbols.
  modport master (
    output i_valid, i_data, i_ami,
    input  o_valid, o_code, o_pos, o_neg
  );

  // Encoder side.
  modport slave (
    input  i_valid, i_data, i_ami,
    output o_valid, o_code, o_pos, o_neg
  );
endinterface

// File: rtl/hdbn_encoder.sv
// HDB-N / AMI line encoder.
// A delay line of ORDER+1 symbol stages lets a zero run be recognised at its
// (ORDER+1)-th zero while its first zero is still in flight, so that first
// zero can be retro-coded as a B pulse. Polarity is assigned as symbols leave.
//   i_clk : clock, rising edge
//   i_rst : synchronous active-high reset
//   bus   : hdbn_encoder_if.slave (input beats, output symbols)
module hdbn_encoder #(
  parameter int unsigned ORDER = 3
) (
  input  logic          i_clk,
  input  logic          i_rst,
  hdbn_encoder_if.slave bus
);

  localparam int unsigned CODE_W = 2;
  localparam int unsigned CNT_W  = $clog2(ORDER + 1);

  localparam logic [CODE_W-1:0] SYM_ZERO = 2'b00;
  localparam logic [CODE_W-1:0] SYM_ONE  = 2'b01;
  localparam logic [CODE_W-1:0] SYM_V    = 2'b10;
  localparam logic [CODE_W-1:0] SYM_B    = 2'b11;

  logic [CODE_W-1:0] s_code [0:ORDER];
  logic              s_vld  [0:ORDER];
  logic [CNT_W-1:0]  zero_cnt;
  logic              parity;    // odd number of pulses since last V
  logic              last_pos;  // polarity of the most recent B/one pulse

  logic              sub;
  logic [CODE_W-1:0] head_code;
  logic [CODE_W-1:0] tail_code;
  logic              tail_vld;

  // Symbol entering s[0] and symbol entering s[ORDER] on this beat.
  always_comb begin
    sub       = 1'b0;
    head_code = SYM_ZERO;
    tail_code = s_code[ORDER-1];
    tail_vld  = s_vld[ORDER-1];
    sub       = !bus.i_ami && !bus.i_data && (zero_cnt == CNT_W'(ORDER));
    head_code = sub ? SYM_V : {1'b0, bus.i_data};
    // Even parity: first zero of the run becomes B so the V alternates.
    if (sub && !parity) begin
      tail_code = SYM_B;
    end
  end

  // Delay line, run/parity tracking and registered line output.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k <= int'(ORDER); k++) begin
        s_code[k] <= SYM_ZERO;
        s_vld[k]  <= 1'b0;
      end
      zero_cnt   <= '0;
      parity     <= 1'b0;
      last_pos   <= 1'b0;
      bus.o_valid <= 1'b0;
      bus.o_code  <= SYM_ZERO;
      bus.o_pos   <= 1'b0;
      bus.o_neg   <= 1'b0;
    end else begin
      bus.o_valid <= 1'b0;
      if (bus.i_valid) begin
        s_code[0] <= head_code;
        s_vld[0]  <= 1'b1;
        for (int k = 1; k < int'(ORDER); k++) begin
          s_code[k] <= s_code[k-1];
          s_vld[k]  <= s_vld[k-1];
        end
        s_code[ORDER] <= tail_code;
        s_vld[ORDER]  <= tail_vld;

        if (bus.i_ami || bus.i_data || sub) begin
          zero_cnt <= '0;
        end else begin
          zero_cnt <= zero_cnt + CNT_W'(1);
        end

        if (sub) begin
          parity <= 1'b0;
        end else if (bus.i_data) begin
          parity <= !parity;
        end

        if (tail_vld) begin
          bus.o_valid <= 1'b1;
          bus.o_code  <= tail_code;
          unique case (tail_code)
            SYM_ONE, SYM_B: begin
              bus.o_pos <= !last_pos;
              bus.o_neg <= last_pos;
              last_pos  <= !last_pos;
            end
            SYM_V: begin
              // Violation repeats the previous pulse polarity.
              bus.o_pos <= last_pos;
              bus.o_neg <= !last_pos;
            end
            default: begin
              bus.o_pos <= 1'b0;
              bus.o_neg <= 1'b0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: doc/hdbn_encoder.md
HDBN_ENCODER -- requirements
Module: hdbn_encoder

Interface
REQ-001 SHALL have parameter ORDER, default 3, the maximum allowed zero run: ORDER+1 consecutive zeros trigger substitution (3 = HDB3); legal range 2..7.
REQ-002 SHALL have port i_clk  input  1  single clock; all logic rising-edge.
REQ-003 SHALL have port i_rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port i_valid  input  1  qualifies i_data; each cycle with i_valid=1 is one "beat".
REQ-005 SHALL have port i_data  input  1  binary NRZ data bit.
REQ-006 SHALL have port i_ami  input  1  1 = plain AMI, no substitution; 0 = HDB-ORDER; sampled per beat.
REQ-007 SHALL have port o_valid  output  1  one-cycle strobe marking a new output symbol.
REQ-008 SHALL have port o_code  output  2  symbol type: 00 zero, 01 one, 10 V, 11 B.
REQ-009 SHALL have port o_pos  output  1  positive pulse; SHALL have port o_neg  output  1  negative pulse; never both 1.

Function
REQ-010 SHALL hold a symbol delay line s[0..ORDER] (2-bit code plus valid bit per stage), advanced only on beats; s[0] takes the new symbol, s[k] takes s[k-1].
REQ-011 SHALL keep a zero-run counter: +1 on a beat with i_data=0, cleared on i_data=1, on substitution and whenever i_ami=1.
REQ-012 SHALL keep a parity bit (pulses since last V): toggles on a beat with i_data=1, cleared to 0 on any substitution.
REQ-013 On a beat with i_ami=0, i_data=0 and counter==ORDER, SHALL write V (10) into s[0].
REQ-014 In that same beat, if parity==0, SHALL rewrite the symbol moving into s[ORDER] (the first zero of the run) as B (11); if parity==1 it stays zero (000V form).
REQ-015 Otherwise SHALL write 01 for i_data=1 and 00 for i_data=0 into s[0].
REQ-016 A run of 2*(ORDER+1) zeros SHALL produce two independent substitutions; a run longer than ORDER+1 but shorter SHALL leave trailing zeros untouched.
REQ-017 On each beat where s[ORDER] is valid, SHALL register its symbol onto o_code and assign polarity: 01 and 11 alternate relative to the last-pulse polarity register and update it; 10 takes the same polarity as the last pulse and does not update it; 00 drives o_pos=o_neg=0.
REQ-018 SHALL assert o_valid for exactly one cycle after such a beat; o_code/o_pos/o_neg SHALL hold between strobes.
REQ-019 Latency: symbol of input beat k SHALL appear, with o_valid=1, in the cycle after input beat k+ORDER; cycles without i_valid SHALL stall the pipeline without loss.
REQ-020 The first ORDER beats after reset SHALL produce no o_valid (delay-line fill, stage valid bits 0).
REQ-021 Toggling i_ami mid-stream SHALL take effect at the next beat; symbols already in the delay line are not re-coded.

Reset
REQ-022 While i_rst=1, SHALL clear o_valid, o_code, o_pos, o_neg, all delay-line stages and valid bits, zero counter and parity to 0, and set last-pulse polarity to negative (first pulse positive).
REQ-023 Reset asserted mid-stream SHALL discard all in-flight symbols; i_valid is ignored during reset.

Verification (ORDER=3, i_ami=0 unless stated, i_valid=1 every cycle)
REQ-024 Hold i_rst=1 two cycles, i_data=1 -> o_valid=0, o_code=00, o_pos=o_neg=0 throughout.
REQ-025 After reset send 1,1,1,1 -> four strobes starting cycle after beat 4: o_code 01 each, polarity +,-,+,-.
REQ-026 After reset send 0,0,0,0 -> o_code 11,00,00,10 with B=+, V=+ (B00V, parity even).
REQ-027 After reset send 1,0,0,0,0 -> o_code 01,00,00,00,10 with 1=+, V=+ (000V, parity odd); then 1 -> 01 at -.
REQ-028 Send 1,0,0,0,0 with i_valid deasserted for 5 cycles between each beat -> identical symbol/polarity sequence, o_valid only after beats.
REQ-029 i_ami=1, send 1,0,0,0,0,1 -> o_code 01,00,00,00,00,01 polarity +,0,0,0,0,-; assert i_rst mid-sequence -> no further strobes until 4 new beats.
